// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate tick, beam counters, sync/blank decode, frame strobe.
// Optional macro VGA_PIPE_ALIGN_EN delays hsync/vsync/video_on by one pixel to match registered colour pipelines.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]       HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_next;
   logic             hsync_d;
   logic             vsync_d;
   logic             video_d;

   always_comb begin
      div_next = (div == DIV_MAX) ? '0 : div + 1'b1;
   end

   // p_tick is registered from the next divider value so it stays low while reset is held,
   // even when CLK_DIV=1 would otherwise make it constantly high.
   always_ff @(posedge clk) begin
      if (reset) begin
         div    <= '0;
         p_tick <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
      end else begin
         div    <= div_next;
         p_tick <= (div_next == DIV_MAX);
         if (p_tick) begin
            if (h_cnt == H_MAX) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   always_comb begin
      hsync_d = ~((h_cnt >= HS_START) && (h_cnt <= HS_END));
      vsync_d = ~((v_cnt >= VS_START) && (v_cnt <= VS_END));
      video_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      frame   = p_tick && (h_cnt == 10'd0) && (v_cnt == V_VIS);
   end

`ifdef VGA_PIPE_ALIGN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b0;
      end else if (p_tick) begin
         hsync    <= hsync_d;
         vsync    <= vsync_d;
         video_on <= video_d;
      end
   end
`else
   always_comb begin
      hsync    = hsync_d;
      vsync    = vsync_d;
      video_on = video_d;
   end
`endif

endmodule
